// File: rtl/md_unit.sv
// HI/LO multiply/divide unit for the E stage: MULT/MULTU/DIV/DIVU run for a fixed cycle count.
// Define MD_TRACE_EN to print a trace line for every HI/LO write.
module md_unit #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  op,
  input  logic [31:0] A,
  input  logic [31:0] B,
  input  logic [31:0] pc,
  output logic        busy,
  output logic [31:0] HI,
  output logic [31:0] LO
);

  localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CW = $clog2(MAX_CYCLES + 1);

  typedef enum logic {IDLE, RUN} state_t;

  state_t        state_reg;
  logic [CW-1:0] count_reg;
  logic [1:0]    op_reg;
  logic [31:0]   a_reg, b_reg;
  logic [31:0]   hi_reg, lo_reg;
  logic          busy_reg;
  logic [31:0]   hi_next, lo_next;

`ifdef MD_TRACE_EN
  logic [31:0] pc_reg;
`else
  logic unused_pc;
  assign unused_pc = ^pc;
`endif

  // op_reg[0] selects unsigned; op_reg[1] selects divide.
  logic        sa, sb;
  logic [63:0] prod;
  logic [31:0] abs_a, abs_b, divisor, q_mag, r_mag;

  always_comb begin
    sa      = ~op_reg[0] & a_reg[31];
    sb      = ~op_reg[0] & b_reg[31];
    prod    = {{32{sa}}, a_reg} * {{32{sb}}, b_reg};
    abs_a   = sa ? -a_reg : a_reg;
    abs_b   = sb ? -b_reg : b_reg;
    divisor = (b_reg == 32'd0) ? 32'd1 : abs_b;
    q_mag   = abs_a / divisor;
    r_mag   = abs_a % divisor;
    hi_next = prod[63:32];
    lo_next = prod[31:0];
    if (op_reg[1]) begin
      if (b_reg == 32'd0) begin
        hi_next = a_reg;
        lo_next = 32'hFFFF_FFFF;
      end else begin
        // Magnitude divide then re-sign: quotient truncates toward zero, remainder follows dividend.
        lo_next = (sa ^ sb) ? -q_mag : q_mag;
        hi_next = sa ? -r_mag : r_mag;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_reg <= IDLE;
      count_reg <= '0;
      hi_reg    <= '0;
      lo_reg    <= '0;
      busy_reg  <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (start) begin
            if (!op[2]) begin
              op_reg    <= op[1:0];
              a_reg     <= A;
              b_reg     <= B;
              count_reg <= op[1] ? CW'(DIV_CYCLES) : CW'(MULT_CYCLES);
              state_reg <= RUN;
              busy_reg  <= 1'b1;
`ifdef MD_TRACE_EN
              pc_reg    <= pc;
`endif
            end else if (op == 3'd4) begin
              hi_reg <= A;
`ifdef MD_TRACE_EN
              $display("%d@%h: $hi <= %h", $time, pc, A);
`endif
            end else if (op == 3'd5) begin
              lo_reg <= A;
`ifdef MD_TRACE_EN
              $display("%d@%h: $lo <= %h", $time, pc, A);
`endif
            end
          end
        end
        RUN: begin
          count_reg <= count_reg - 1'b1;
          if (count_reg == CW'(1)) begin
            hi_reg    <= hi_next;
            lo_reg    <= lo_next;
            state_reg <= IDLE;
            busy_reg  <= 1'b0;
`ifdef MD_TRACE_EN
            $display("%d@%h: $hi <= %h", $time, pc_reg, hi_next);
            $display("%d@%h: $lo <= %h", $time, pc_reg, lo_next);
`endif
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign busy = busy_reg;
  assign HI   = hi_reg;
  assign LO   = lo_reg;

endmodule

// File: tb/tb_md_unit.sv
// Directed bench for md_unit: per-cycle comparison against an arithmetic model plus literal checks.
module tb_md_unit;
  localparam int MC = 5;
  localparam int DC = 10;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic [2:0]  op = 3'd7;
  logic [31:0] A = '0, B = '0, pc = '0;
  logic        busy;
  logic [31:0] HI, LO;

  int errors = 0;
  int checks = 0;
  bit chk_en = 1'b0;

  md_unit #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op),
    .A(A), .B(B), .pc(pc), .busy(busy), .HI(HI), .LO(LO)
  );

  always #5 clk = ~clk;

  // Model: architectural HI/LO, a pending result and the number of busy cycles left.
  logic [31:0] m_hi = '0, m_lo = '0, p_hi = '0, p_lo = '0;
  int remaining = 0;

  always @(posedge clk) begin
    if (!reset) begin
      remaining = 0;
      m_hi = '0;
      m_lo = '0;
    end else if (remaining > 0) begin
      remaining = remaining - 1;
      if (remaining == 0) begin
        m_hi = p_hi;
        m_lo = p_lo;
      end
    end else if (start) begin
      int ia, ib;
      longint sp, sq, sr;
      longint unsigned ua, ub, up;
      ia = A; ib = B; ua = A; ub = B;
      case (op)
        3'd0: begin sp = longint'(ia) * longint'(ib); p_hi = sp[63:32]; p_lo = sp[31:0]; remaining = MC; end
        3'd1: begin up = ua * ub; p_hi = up[63:32]; p_lo = up[31:0]; remaining = MC; end
        3'd2, 3'd3: begin
          if (B == 0) begin
            p_hi = A; p_lo = 32'hFFFF_FFFF;
          end else if (op == 3'd2) begin
            sq = longint'(ia) / longint'(ib); sr = longint'(ia) % longint'(ib);
            p_lo = sq[31:0]; p_hi = sr[31:0];
          end else begin
            up = ua / ub; p_lo = up[31:0];
            up = ua % ub; p_hi = up[31:0];
          end
          remaining = DC;
        end
        3'd4: m_hi = A;
        3'd5: m_lo = A;
        default: ;
      endcase
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      checks++;
      if (busy !== (remaining > 0) || HI !== m_hi || LO !== m_lo) begin
        errors++;
        $display("FAIL cycle t=%0t: got busy=%b HI=%h LO=%h expected busy=%b HI=%h LO=%h",
                 $time, busy, HI, LO, remaining > 0, m_hi, m_lo);
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end else
      $display("ok   %s: %h", name, act);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Launch an op, scramble A/B while running, and return the number of busy cycles observed.
  task automatic run_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b, output int n);
    start = 1'b1; op = o; A = a; B = b; pc = pc + 32'd4;
    tick();
    start = 1'b0; op = 3'd7; A = $urandom; B = $urandom;
    n = 0;
    while (busy === 1'b1 && n < 200) begin
      n++;
      tick();
    end
  endtask

  int n;

  initial begin
    tick();
    chk_en = 1'b1;
    tick();
    check("reset busy", {31'd0, busy}, 32'd0);
    check("reset HI", HI, 32'd0);
    check("reset LO", LO, 32'd0);
    reset = 1'b1;
    tick();

    run_op(3'd0, 32'hFFFF_FFFF, 32'h0000_0002, n);
    check("mult cycles", n, MC);
    check("mult HI", HI, 32'hFFFF_FFFF);
    check("mult LO", LO, 32'hFFFF_FFFE);

    run_op(3'd1, 32'hFFFF_FFFF, 32'h0000_0002, n);
    check("multu HI", HI, 32'h0000_0001);
    check("multu LO", LO, 32'hFFFF_FFFE);

    run_op(3'd2, 32'hFFFF_FFF9, 32'h0000_0002, n);
    check("div cycles", n, DC);
    check("div LO", LO, 32'hFFFF_FFFD);
    check("div HI", HI, 32'hFFFF_FFFF);

    run_op(3'd3, 32'd7, 32'd2, n);
    check("divu LO", LO, 32'd3);
    check("divu HI", HI, 32'd1);

    run_op(3'd2, 32'h1234_5678, 32'd0, n);
    check("div0 cycles", n, DC);
    check("div0 LO", LO, 32'hFFFF_FFFF);
    check("div0 HI", HI, 32'h1234_5678);

    run_op(3'd2, 32'h8000_0000, 32'hFFFF_FFFF, n);
    check("divovf LO", LO, 32'h8000_0000);
    check("divovf HI", HI, 32'h0000_0000);

    start = 1'b1; op = 3'd4; A = 32'hDEAD_BEEF;
    tick();
    start = 1'b0;
    check("mthi HI", HI, 32'hDEAD_BEEF);
    check("mthi busy", {31'd0, busy}, 32'd0);
    start = 1'b1; op = 3'd6; A = 32'h5555_5555;
    tick();
    start = 1'b0;
    check("nop HI", HI, 32'hDEAD_BEEF);
    check("nop LO", LO, 32'h8000_0000);

    // MTLO issued mid-run must be dropped.
    start = 1'b1; op = 3'd0; A = 32'h0001_0000; B = 32'h0003_0000;
    tick();
    start = 1'b0;
    tick();
    start = 1'b1; op = 3'd5; A = 32'd1;
    tick();
    start = 1'b0; op = 3'd7;
    check("run HI held", HI, 32'hDEAD_BEEF);
    n = 0;
    while (busy === 1'b1 && n < 200) begin n++; tick(); end
    check("mtlo dropped LO", LO, 32'h0000_0000);
    check("mtlo dropped HI", HI, 32'h0000_0003);

    // Reset mid-run aborts the op.
    start = 1'b1; op = 3'd0; A = 32'd3; B = 32'd4;
    tick();
    start = 1'b0;
    tick();
    reset = 1'b0;
    tick();
    reset = 1'b1;
    check("abort busy", {31'd0, busy}, 32'd0);
    check("abort HI", HI, 32'd0);
    check("abort LO", LO, 32'd0);
    repeat (DC) tick();
    check("abort LO later", LO, 32'd0);

    chk_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/md_unit.md
Name: md_unit

Overview:
- Multiply/divide unit in the E stage of the 5-stage MIPS pipeline.
- Holds the architectural HI/LO registers and runs MULT/MULTU/DIV/DIVU over a fixed number of cycles.
- Reports busy to the hazard logic, which stalls D-stage MD/MFHI/MFLO instructions.
- HI/LO feed the E-stage result mux, whose output travels down the pipeline to the register-file write port (MFHI/MFLO results).

Parameters:
MULT_CYCLES, 5, cycles busy is high for MULT/MULTU (must be >= 1)
DIV_CYCLES, 10, cycles busy is high for DIV/DIVU (must be >= 1)

Ports:
clk  input  1  clock, all state updates on posedge
reset  input  1  synchronous, active-low; state cleared on posedge clk while reset==0
start  input  1  launch op this cycle (qualified by op)
op  input  3  0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 MTHI, 5 MTLO, 6/7 no-op
A  input  32  rs operand
B  input  32  rt operand
pc  input  32  PC of the launching instruction (trace only)
busy  output  1  operation in progress
HI  output  32  HI register
LO  output  32  LO register

Behaviour:
- Reset (reset==0 at posedge): state=IDLE, counter=0, HI=LO=0, busy=0; any in-flight op is discarded.
- FSM states:
  - IDLE: busy=0.
  - RUN: busy=1.
- IDLE & start & op in {0..3}:
  - Latch op, A, B.
  - Load counter with MULT_CYCLES (op 0/1) or DIV_CYCLES (op 2/3).
  - Go to RUN.
- IDLE & start & op==4: HI<=A at this edge, stay IDLE. op==5: LO<=A likewise.
- IDLE & start & op in {6,7}: no effect.
- RUN: counter decrements each cycle.
  - On the edge where counter==1, write the result to HI/LO and go to IDLE.
  - Busy is therefore high for exactly N cycles after the start edge; new HI/LO are visible in the first cycle busy is low.
- start while RUN: ignored entirely, including MTHI/MTLO. Hazard logic guarantees no such request; the bench checks it is dropped.
- HI/LO never change during RUN; reads in RUN return the pre-op values.
- MULT: signed 32x32->64; HI=product[63:32], LO=product[31:0].
- MULTU: unsigned, same split.
- DIV: signed; LO=quotient truncated toward zero; HI=remainder with the sign of the dividend.
  - A=32'h80000000, B=32'hFFFFFFFF: LO=32'h80000000, HI=0.
- DIVU: unsigned quotient/remainder.
- Divide by zero (B==0, DIV or DIVU): LO=32'hFFFFFFFF, HI=A. Still takes DIV_CYCLES.
- Operands are latched at start; changes on A/B during RUN have no effect.
- Reset asserted during RUN: abort at that edge, HI=LO=0, busy=0 next cycle.

Optional Feature:
MD_TRACE_EN
- Defined: on every HI/LO write (op completion, MTHI, MTLO), print one line per written register.
  - Format: "%d@%h: $hi <= %h" / "%d@%h: $lo <= %h", using $time, the latched pc of the launching instruction, and the value.
  - Completion of MULT/DIV prints hi then lo.
- Undefined: no display statements; the pc input is unused. Functional behaviour is identical.

Test Plan:
- MULT A=32'hFFFFFFFF B=32'h00000002 -> busy high 5 cycles, then HI=32'hFFFFFFFF LO=32'hFFFFFFFE.
- MULTU same operands -> HI=32'h00000001 LO=32'hFFFFFFFE.
- DIV A=32'hFFFFFFF9 (-7) B=2 -> busy 10 cycles, then LO=32'hFFFFFFFD HI=32'hFFFFFFFF.
- DIVU A=7 B=2 -> LO=3 HI=1.
- DIV B=0, A=32'h12345678 -> LO=32'hFFFFFFFF HI=32'h12345678.
- DIV A=32'h80000000 B=32'hFFFFFFFF -> LO=32'h80000000 HI=0.
- MTHI A=32'hDEADBEEF while IDLE -> HI=32'hDEADBEEF next cycle, busy stays 0.
- MULT started, then MTLO A=1 at cycle 2 -> MTLO ignored; final LO is the product.
- MULT 3x4 started, reset=0 at cycle 3 -> busy=0 and HI=LO=0 next cycle; no later HI/LO write.
